audio_packetizer: RTL and testbench

- Upstream feeder of the transport/connected-system stage.
- Buffers 16-bit audio samples from the local audio path in a FIFO.
- Frames them into fixed-length packets (header, samples, checksum) addressed to the dialled phone number.
- Streams packet words to transport one word at a time, pacing itself on transport's busy flag.

---
 rtl/audio_packetizer.sv | 151 +++++++++++++++
 tb/tb_audio_packetizer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_packetizer.sv
// audio_packetizer
// Buffers 16-bit audio samples in a FIFO and frames them into fixed-length
// packets (header, SAMPLES_PER_PKT data words, checksum) for the transport
// stage. It issues one word per non-busy cycle.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   sendData      call-active enable; gates sample capture and packet start
//   phoneNum      destination number, latched when a packet starts
//   audioIn       audio sample, valid when audioValid=1
//   audioValid    one-cycle sample strobe
//   transportBusy transport cannot accept a word this cycle
//   packetOut     packet word
//   cmdOut        word type: 00 idle, 01 header, 10 data, 11 checksum
//   packetValid   packetOut/cmdOut valid this cycle
//   overflow      sticky; a sample was dropped on a full FIFO
//   fifoCount     current FIFO occupancy
module audio_packetizer #(
    parameter int          SAMPLES_PER_PKT = 8,
    parameter int          FIFO_DEPTH      = 16,
    parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sendData,
    input  logic [7:0]                    phoneNum,
    input  logic [15:0]                   audioIn,
    input  logic                          audioValid,
    input  logic                          transportBusy,
    output logic [15:0]                   packetOut,
    output logic [1:0]                    cmdOut,
    output logic                          packetValid,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PKT_COUNT  = (AW+1)'(SAMPLES_PER_PKT);
    localparam logic [CW-1:0] LAST_IDX   = CW'(SAMPLES_PER_PKT - 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, CSUM} state_e;

    state_e        state;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [7:0]    phoneLatch;
    logic [15:0]   csum;
    logic [CW-1:0] dataIdx;

    logic          pop;
    logic          push;
    logic          dropSample;
    logic [15:0]   headerWord;
    logic [15:0]   headSample;

    always_comb begin
        pop        = (state == DATA) && !transportBusy;
        // A full FIFO still accepts a sample when a pop frees a slot this edge.
        push       = audioValid && sendData && ((fifoCount < FULL_COUNT) || pop);
        dropSample = audioValid && sendData && !push;
        headerWord = {SYNC_BYTE, phoneLatch};
        headSample = mem[rdPtr];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= audioIn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                fifoCount <= fifoCount + 1'b1;
            end else if (pop && !push) begin
                fifoCount <= fifoCount - 1'b1;
            end
            if (dropSample) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            packetOut   <= '0;
            cmdOut      <= 2'b00;
            packetValid <= 1'b0;
            phoneLatch  <= '0;
            csum        <= '0;
            dataIdx     <= '0;
        end else if (state == IDLE) begin
            packetValid <= 1'b0;
            cmdOut      <= 2'b00;
            if (sendData && (fifoCount >= PKT_COUNT)) begin
                phoneLatch <= phoneNum;
                csum       <= '0;
                dataIdx    <= '0;
                state      <= HEADER;
            end
        end else if (transportBusy) begin
            // Stall: drop the strobe, hold the last word, freeze state.
            packetValid <= 1'b0;
        end else begin
            packetValid <= 1'b1;
            case (state)
                HEADER: begin
                    packetOut <= headerWord;
                    cmdOut    <= 2'b01;
                    csum      <= csum + headerWord;
                    state     <= DATA;
                end
                DATA: begin
                    packetOut <= headSample;
                    cmdOut    <= 2'b10;
                    csum      <= csum + headSample;
                    dataIdx   <= dataIdx + 1'b1;
                    if (dataIdx == LAST_IDX) begin
                        state <= CSUM;
                    end
                end
                CSUM: begin
                    packetOut <= csum;
                    cmdOut    <= 2'b11;
                    state     <= IDLE;
                end
                default: begin
                    packetValid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_packetizer.sv
// tb_audio_packetizer
// Self-checking bench for audio_packetizer. Accepted samples are grouped into
// packets by a queue-based model; every word the DUT strobes is compared in
// order against the expected word stream.
module tb_audio_packetizer;

    localparam int SPP = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sendData;
    logic [7:0]  phoneNum;
    logic [15:0] audioIn;
    logic        audioValid;
    logic        transportBusy;
    logic [15:0] packetOut;
    logic [1:0]  cmdOut;
    logic        packetValid;
    logic        overflow;
    logic [4:0]  fifoCount;

    audio_packetizer #(
        .SAMPLES_PER_PKT(SPP),
        .FIFO_DEPTH(16),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sendData(sendData),
        .phoneNum(phoneNum),
        .audioIn(audioIn),
        .audioValid(audioValid),
        .transportBusy(transportBusy),
        .packetOut(packetOut),
        .cmdOut(cmdOut),
        .packetValid(packetValid),
        .overflow(overflow),
        .fifoCount(fifoCount)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sampleQ[$];
    logic [17:0] expQ[$];
    logic [7:0]  curPhone;
    int          wordsSeen = 0;
    int          validRun  = 0;
    int          maxRun    = 0;
    logic [15:0] lastCsum  = '0;
    logic        randBusy  = 1'b0;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every SPP accepted samples form one packet: header, samples, 16-bit sum.
    function automatic void modelAccept(input logic [15:0] s);
        logic [15:0] hdr;
        logic [15:0] sum;
        sampleQ.push_back(s);
        if (sampleQ.size() == SPP) begin
            hdr = {8'hA5, curPhone};
            sum = hdr;
            expQ.push_back({2'b01, hdr});
            foreach (sampleQ[i]) begin
                expQ.push_back({2'b10, sampleQ[i]});
                sum = sum + sampleQ[i];
            end
            expQ.push_back({2'b11, sum});
            sampleQ.delete();
        end
    endfunction

    always @(negedge clk) begin
        if (reset && packetValid) begin
            wordsSeen++;
            validRun++;
            if (validRun > maxRun) maxRun = validRun;
            if (expQ.size() == 0) begin
                checkValue("spurious_valid", 32'(packetValid), 32'd0);
            end else begin
                checkValue("word", 32'({cmdOut, packetOut}), 32'(expQ.pop_front()));
                if (cmdOut == 2'b11) lastCsum = packetOut;
            end
        end else begin
            validRun = 0;
        end
    end

    always @(negedge clk) begin
        if (randBusy) transportBusy = ($urandom_range(3) == 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pushSample(input logic [15:0] s, input bit accept);
        @(negedge clk);
        audioIn    = s;
        audioValid = 1'b1;
        if (accept) modelAccept(s);
        @(negedge clk);
        audioValid = 1'b0;
    endtask

    task automatic applyReset();
        reset      = 1'b0;
        audioValid = 1'b0;
        repeat (3) @(negedge clk);
        expQ.delete();
        sampleQ.delete();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitWords(input int target, input int budget);
        int n = 0;
        while (wordsSeen < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkValue("wait_words", 32'(wordsSeen >= target), 32'd1);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkValue("drain", 32'(expQ.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        reset         = 1'b0;
        sendData      = 1'b0;
        phoneNum      = 8'h00;
        audioIn       = '0;
        audioValid    = 1'b0;
        transportBusy = 1'b0;
        curPhone      = 8'h00;

        // Reset state
        #12;
        checkValue("rst_packetOut", 32'(packetOut), 32'd0);
        checkValue("rst_cmdOut", 32'(cmdOut), 32'd0);
        checkValue("rst_valid", 32'(packetValid), 32'd0);
        checkValue("rst_overflow", 32'(overflow), 32'd0);
        checkValue("rst_count", 32'(fifoCount), 32'd0);
        applyReset();

        // Basic framing
        phoneNum = 8'h17;
        curPhone = 8'h17;
        sendData = 1'b1;
        maxRun   = 0;
        for (int i = 1; i <= 8; i++) pushSample(16'(i), 1'b1);
        waitDrain(200);
        checkValue("basic_run", 32'(maxRun), 32'd10);
        checkValue("basic_csum", 32'(lastCsum), 32'hA53B);
        checkValue("basic_count", 32'(fifoCount), 32'd0);

        // Checksum wrap
        for (int i = 0; i < 8; i++) pushSample(16'hFFFF, 1'b1);
        waitDrain(200);
        checkValue("wrap_csum", 32'(lastCsum), 32'hA50F);

        // Back-pressure after the 3rd data word
        for (int i = 1; i <= 8; i++) pushSample(16'(i), 1'b1);
        base = wordsSeen;
        waitWords(base + 4, 100);
        transportBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkValue("bp_valid", 32'(packetValid), 32'd0);
            checkValue("bp_hold", 32'(packetOut), 32'h0003);
        end
        transportBusy = 1'b0;
        waitDrain(200);
        checkValue("bp_csum", 32'(lastCsum), 32'hA53B);
        checkValue("bp_words", 32'(wordsSeen - base), 32'd10);

        // Overflow: 17 pushes into a stalled 16-deep FIFO
        transportBusy = 1'b1;
        for (int i = 1; i <= 17; i++) pushSample(16'(i), i <= 16);
        @(negedge clk);
        #1;
        checkValue("ovf_count", 32'(fifoCount), 32'd16);
        checkValue("ovf_flag", 32'(overflow), 32'd1);
        checkValue("ovf_valid", 32'(packetValid), 32'd0);
        transportBusy = 1'b0;
        waitDrain(300);
        checkValue("ovf_sticky", 32'(overflow), 32'd1);
        applyReset();
        checkValue("ovf_cleared", 32'(overflow), 32'd0);

        // Gating: sendData=0 ignores samples
        sendData = 1'b0;
        base     = wordsSeen;
        for (int i = 0; i < 10; i++) pushSample(16'($urandom), 1'b0);
        repeat (5) @(negedge clk);
        checkValue("gate_count", 32'(fifoCount), 32'd0);
        checkValue("gate_overflow", 32'(overflow), 32'd0);
        checkValue("gate_words", 32'(wordsSeen), 32'(base));

        // Randomized traffic with random back-pressure
        sendData = 1'b1;
        phoneNum = 8'($urandom);
        curPhone = phoneNum;
        randBusy = 1'b1;
        for (int i = 0; i < 48; i++) begin
            pushSample(16'($urandom), 1'b1);
            repeat ($urandom_range(2, 5)) @(negedge clk);
        end
        waitDrain(2000);
        randBusy = 1'b0;
        @(negedge clk);
        transportBusy = 1'b0;
        checkValue("rand_overflow", 32'(overflow), 32'd0);
        checkValue("rand_count", 32'(fifoCount), 32'd0);

        // Reset mid-packet after the 4th data word
        phoneNum = 8'h42;
        curPhone = 8'h42;
        for (int i = 1; i <= 8; i++) pushSample(16'(16'h0200 + i), 1'b1);
        base = wordsSeen;
        waitWords(base + 5, 100);
        reset = 1'b0;
        #1;
        checkValue("mid_rst_packetOut", 32'(packetOut), 32'd0);
        checkValue("mid_rst_cmdOut", 32'(cmdOut), 32'd0);
        checkValue("mid_rst_valid", 32'(packetValid), 32'd0);
        checkValue("mid_rst_count", 32'(fifoCount), 32'd0);
        expQ.delete();
        sampleQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base  = wordsSeen;
        for (int i = 1; i <= 8; i++) pushSample(16'(16'h0300 + i), 1'b1);
        waitDrain(200);
        checkValue("post_rst_words", 32'(wordsSeen - base), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
